rotating_square_ctrl: RTL

Parametrised rotating-square animator for an N-digit, common-anode 7-segment display. A "square" glyph travels around the display: upper square along the top row left to right, then lower square along the bottom row right to left, or the reverse. Step rate, pause, direction and a top-row-only mode are selectable. The block sits between the board-level segment/anode pins and the user controls, and produces one lit digit at a time, so no refresh multiplexer is needed.

---
 rtl/rotating_square_ctrl_if.sv | 29 ++
 rtl/rotating_square_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/rotating_square_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : rotating_square_ctrl_if
// Function : Control and display bundle of the rotating-square animator.
// Revision : 1.0  initial release
// ============================================================================
interface rotating_square_ctrl_if #(
    parameter int N_DIGITS = 8,
    parameter int PW       = $clog2(2 * N_DIGITS)
);
    logic                en;
    logic                cw;
    logic                mode;
    logic [6:0]          seg;
    logic [N_DIGITS-1:0] an;
    logic [PW-1:0]       pos;
    logic                step;

    modport master (
        output en, cw, mode,
        input  seg, an, pos, step
    );

    modport slave (
        input  en, cw, mode,
        output seg, an, pos, step
    );
endinterface
`default_nettype wire

// File: rtl/rotating_square_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotating_square_ctrl
// Function : Square glyph circling an N-digit common-anode 7-segment display.
// Revision : 1.0  initial release
// ============================================================================
module rotating_square_ctrl #(
    parameter int N_DIGITS = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rotating_square_ctrl_if.slave bus
);
    localparam int PW      = $clog2(2 * N_DIGITS);
    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(TICK_DIV - 1);
    localparam logic [PW-1:0]      c_N         = PW'(N_DIGITS);
    localparam logic [PW-1:0]      c_TOP_LAST  = PW'(N_DIGITS - 1);
    localparam logic [PW-1:0]      c_LOOP_LAST = PW'(2 * N_DIGITS - 1);
    localparam logic [PW:0]        c_LOOP_LEN  = (PW + 1)'(2 * N_DIGITS);
    localparam logic [6:0]         c_SEG_UPPER = 7'b0011100;
    localparam logic [6:0]         c_SEG_LOWER = 7'b1100010;
    localparam logic [6:0]         c_SEG_OFF   = 7'h7F;

    logic [c_CNT_W-1:0]  r_cnt;
    logic [PW-1:0]       r_pos;
    logic                r_step;

    logic                w_adv;
    logic                w_valid;
    logic                w_upper;
    logic [PW-1:0]       w_pos_next;
    logic [PW-1:0]       w_idx;
    logic [6:0]          w_seg;
    logic [N_DIGITS-1:0] w_an;

    assign w_adv   = bus.en && (r_cnt == c_CNT_MAX);
    // Extra bit keeps the range test meaningful when 2*N_DIGITS is a power of two.
    assign w_valid = ({1'b0, r_pos} < c_LOOP_LEN);
    assign w_upper = (r_pos < c_N);

    always_comb begin
        w_pos_next = '0;
        if (!w_valid) begin
            w_pos_next = '0;
        end else if (bus.mode) begin
            if (!w_upper) begin
                w_pos_next = bus.cw ? '0 : c_TOP_LAST;
            end else if (bus.cw) begin
                w_pos_next = (r_pos == c_TOP_LAST) ? '0 : r_pos + PW'(1);
            end else begin
                w_pos_next = (r_pos == '0) ? c_TOP_LAST : r_pos - PW'(1);
            end
        end else begin
            if (bus.cw) begin
                w_pos_next = (r_pos == c_LOOP_LAST) ? '0 : r_pos + PW'(1);
            end else begin
                w_pos_next = (r_pos == '0) ? c_LOOP_LAST : r_pos - PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_pos  <= '0;
            r_step <= 1'b0;
        end else begin
            if (bus.en) begin
                r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + c_CNT_W'(1);
            end
            if (w_adv) begin
                r_pos <= w_pos_next;
            end
            r_step <= w_adv;
        end
    end

    // Upper square walks left to right, lower square walks back right to left.
    always_comb begin
        w_seg = c_SEG_OFF;
        w_an  = '1;
        w_idx = '0;
        if (w_upper) begin
            w_seg = c_SEG_UPPER;
            w_idx = c_TOP_LAST - r_pos;
        end else if (w_valid) begin
            w_seg = c_SEG_LOWER;
            w_idx = r_pos - c_N;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_valid && (w_idx == PW'(i))) begin
                w_an[i] = 1'b0;
            end
        end
    end

    assign bus.seg  = w_seg;
    assign bus.an   = w_an;
    assign bus.pos  = r_pos;
    assign bus.step = r_step;

endmodule
`default_nettype wire
